bit_serializer: RTL and testbench

Transmit-path stage directly upstream of the bit stuffer. Accepts bytes over a valid/ready handshake, prepends a SYNC byte to each packet and shifts the bits out LSB-first, one per clock, as the stuffer's input bit stream. It honours the stuffer's `pause` by holding the current bit, so no payload bit is lost when a stuff bit is inserted. It flags end-of-packet, and flags underrun when the next byte is not ready in time.

---
 rtl/bit_serializer.sv | 90 +++++++++
 tb/tb_bit_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Byte-to-bit serializer feeding the bit stuffer: prepends SYNC_PATTERN to each
// packet, shifts bits out LSB-first and holds the current bit while pause is high.
module bit_serializer #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       pause,
  output logic       outb,
  output logic       out_active,
  output logic       eop,
  output logic       underrun
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

  state_t     state;
  logic [7:0] buf_data;
  logic       buf_last;
  logic       buf_full;
  logic [7:0] shifter;
  logic [2:0] count;
  logic       cur_last;

  // Every output is decoded from registers only, so pause/in_valid never reach an output combinationally.
  assign in_ready   = !buf_full;
  assign out_active = (state != IDLE);
  assign outb       = out_active & shifter[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      buf_data <= '0;
      buf_last <= 1'b0;
      buf_full <= 1'b0;
      shifter  <= '0;
      count    <= '0;
      cur_last <= 1'b0;
      eop      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the default-low pulses below are
      // overridden later in the same block, and the last assignment wins.
      eop      <= 1'b0;
      underrun <= 1'b0;

      // Accept and drain are mutually exclusive: accept needs an empty buffer, drain a full one.
      if (in_valid && !buf_full) begin
        buf_data <= in_data;
        buf_last <= in_last;
        buf_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (buf_full) begin
            state   <= SYNC;
            shifter <= SYNC_PATTERN;
            count   <= '0;
          end
        end
        default: begin
          if (!pause) begin
            count   <= count + 3'd1;
            shifter <= shifter >> 1;
            if (count == 3'd7) begin
              if (buf_full && (state == SYNC || !cur_last)) begin
                state    <= DATA;
                shifter  <= buf_data;
                cur_last <= buf_last;
                buf_full <= 1'b0;
              end else if (state == DATA && cur_last) begin
                state <= IDLE;
                eop   <= 1'b1;
              end else begin
                state    <= IDLE;
                underrun <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: expected bits and end events are queued
// when bytes are offered and compared as the serializer consumes them.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       pause = 1'b0;
  logic       in_ready, outb, out_active, eop, underrun;

  bit_serializer #(.SYNC_PATTERN(8'h80)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .pause(pause), .outb(outb),
    .out_active(out_active), .eop(eop), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {K_BIT, K_EOP, K_UND} kind_t;
  typedef struct {
    kind_t kind;
    int    val;
  } item_t;

  item_t q[$];
  int checks = 0;
  int failures = 0;
  int act_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 0; i < 8; i++) q.push_back('{K_BIT, int'(b[i])});
  endtask

  task automatic push_end(input kind_t k, input int len);
    q.push_back('{k, len});
  endtask

  // Caller is always #1 after a rising edge.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic first);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    if (first) push_bits(8'h80);
    push_bits(d);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_active();
    int n = 0;
    while (!out_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_active) check("active_timeout", 32'(out_active), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(posedge clk);
    #1;
    check(tag, q.size(), 32'd0);
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    item_t it;
    if (rst) begin
      act_cnt = 0;
    end else begin
      if (out_active) begin
        act_cnt++;
        if (q.size() == 0) begin
          check("spurious_bit", 32'(out_active), 32'd0);
        end else begin
          it = q[0];
          check("bit_kind", 32'(it.kind), 32'(K_BIT));
          check("outb", 32'(outb), 32'(it.val));
          if (!pause && it.kind == K_BIT) void'(q.pop_front());
        end
      end
      if (eop || underrun) begin
        if (q.size() == 0) begin
          check("spurious_end", 32'({eop, underrun}), 32'd0);
        end else begin
          it = q.pop_front();
          check("end_flags", 32'({eop, underrun}), (it.kind == K_EOP) ? 32'd2 : 32'd1);
          check("active_len", 32'(act_cnt), 32'(it.val));
          check("active_at_end", 32'(out_active), 32'd0);
        end
        act_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_active", 32'(out_active), 32'd0);
    check("rst_outb", 32'(outb), 32'd0);
    check("rst_eop", 32'(eop), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte, no pause.
    send_byte(8'hA5, 1'b1, 1'b1);
    push_end(K_EOP, 16);
    wait_drain("drain_a5");

    // Same byte, two pause cycles on data bit 3.
    send_byte(8'hA5, 1'b1, 1'b1);
    push_end(K_EOP, 18);
    wait_active();
    repeat (11) @(posedge clk);
    #1 pause = 1'b1;
    repeat (2) @(posedge clk);
    #1 pause = 1'b0;
    wait_drain("drain_a5_pause");

    // Two-byte packet, second byte offered as soon as the buffer frees.
    send_byte(8'hFF, 1'b0, 1'b1);
    send_byte(8'h00, 1'b1, 1'b0);
    push_end(K_EOP, 24);
    wait_drain("drain_two_byte");

    // Underrun, then a fresh packet starting with SYNC.
    send_byte(8'h3C, 1'b0, 1'b1);
    push_end(K_UND, 16);
    wait_drain("drain_underrun");
    send_byte(8'h01, 1'b1, 1'b1);
    push_end(K_EOP, 16);
    wait_drain("drain_after_underrun");

    // Asynchronous reset during data bit 4 with a byte buffered.
    send_byte(8'h12, 1'b0, 1'b1);
    send_byte(8'h34, 1'b1, 1'b0);
    check("buffered_not_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    q.delete();
    #1;
    check("midrst_out_active", 32'(out_active), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_outb", 32'(outb), 32'd0);
    check("midrst_eop", 32'(eop), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out_active), 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
